// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared state encodings, direction constants and request
//                reduction helpers for the elevator scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest request vector the reduction helpers accept; callers zero-extend.
    localparam int c_MAX_FLOORS = 32;

    // Any request strictly above floor f.
    function automatic logic any_above(input logic [c_MAX_FLOORS-1:0] vec, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < c_MAX_FLOORS; i++) begin
            if (i > f) r = r | vec[i];
        end
        return r;
    endfunction

    // Any request strictly below floor f.
    function automatic logic any_below(input logic [c_MAX_FLOORS-1:0] vec, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < c_MAX_FLOORS; i++) begin
            if (i < f) r = r | vec[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floor_request_reg.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_reg
//  Description : Latched floor-call register with per-floor clear and the
//                above/below request summary relative to the current floor.
//  Revision    : 1.0 - initial release
// ============================================================================
module floor_request_reg
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS = 4,
    localparam int FW         = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] i_call_req,
    input  logic                  i_clr_en,
    input  logic [FW-1:0]         i_clr_floor,
    input  logic [FW-1:0]         i_floor,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_above,
    output logic                  o_below
);

    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_clr;

    // One-hot clear mask for the floor currently being served.
    always_comb begin
        w_clr = '0;
        if (i_clr_en) w_clr[i_clr_floor] = 1'b1;
    end

    // Latch new calls; clear wins so a served floor never re-latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending | i_call_req) & ~w_clr;
    end

    assign o_pending = r_pending;
    assign o_above   = any_above(c_MAX_FLOORS'(r_pending), int'(i_floor));
    assign o_below   = any_below(c_MAX_FLOORS'(r_pending), int'(i_floor));

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_scheduler
//  Description : Collective (SCAN) floor scheduler driving a stepper motor's
//                direction/stop inputs, tracking floor by step count and
//                holding a timed door dwell at each served floor.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS      = 4,
    parameter  int STEPS_PER_FLOOR = 200,
    parameter  int DOOR_CYCLES     = 100_000_000,
    localparam int FW              = $clog2(NUM_FLOORS)
) (
    input  logic                  CLOCK_50,
    input  logic                  Clear_b,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  step_tick,
    output logic                  motor_dir,
    output logic                  motor_stop,
    output logic [FW-1:0]         floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic [1:0]            state
);

    localparam int SW = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
    localparam int DW = (DOOR_CYCLES > 1)     ? $clog2(DOOR_CYCLES)     : 1;

    localparam logic [SW-1:0] c_STEP_LAST  = SW'(STEPS_PER_FLOOR - 1);
    localparam logic [DW-1:0] c_DWELL_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] c_TOP_FLOOR  = FW'(NUM_FLOORS - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_dir, w_dir_nxt;
    logic [FW-1:0]         r_floor, w_floor_nxt;
    logic [SW-1:0]         r_step, w_step_nxt;
    logic [DW-1:0]         r_dwell, w_dwell_nxt;
    logic                  r_stop, r_door;
    logic                  w_clr_en;
    logic [FW-1:0]         w_clr_floor;
    logic [FW-1:0]         w_floor_step;
    logic [NUM_FLOORS-1:0] w_req_all;
    logic                  w_beyond;
    logic                  w_above, w_below;

    floor_request_reg #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_req (
        .clk         (CLOCK_50),
        .rst_n       (Clear_b),
        .i_call_req  (call_req),
        .i_clr_en    (w_clr_en),
        .i_clr_floor (w_clr_floor),
        .i_floor     (r_floor),
        .o_pending   (pending),
        .o_above     (w_above),
        .o_below     (w_below)
    );

    // Arrival checks include this cycle's calls so a same-cycle call stops the car.
    assign w_req_all = pending | call_req;

    // Neighbouring floor in the travel direction, saturated at the shaft ends.
    assign w_floor_step = (r_dir == DIR_UP)
                        ? ((r_floor == c_TOP_FLOOR) ? r_floor : r_floor + FW'(1))
                        : ((r_floor == '0)          ? r_floor : r_floor - FW'(1));

    assign w_beyond = (r_dir == DIR_UP)
                    ? any_above(c_MAX_FLOORS'(w_req_all), int'(w_floor_step))
                    : any_below(c_MAX_FLOORS'(w_req_all), int'(w_floor_step));

    // Next-state, direction, position and counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_floor_nxt = r_floor;
        w_step_nxt  = r_step;
        w_dwell_nxt = r_dwell;
        w_clr_en    = 1'b0;
        w_clr_floor = r_floor;
        case (r_state)
            IDLE: begin
                if (pending[r_floor]) begin
                    w_state_nxt = DOOR;
                    w_clr_en    = 1'b1;
                end else if ((r_dir == DIR_UP) ? w_above : w_below) begin
                    w_state_nxt = MOVE;
                end else if ((r_dir == DIR_UP) ? w_below : w_above) begin
                    w_state_nxt = MOVE;
                    w_dir_nxt   = ~r_dir;
                end
            end
            MOVE: begin
                if (step_tick) begin
                    if (r_step == c_STEP_LAST) begin
                        w_step_nxt  = '0;
                        w_floor_nxt = w_floor_step;
                        if (w_req_all[w_floor_step]) begin
                            w_state_nxt = DOOR;
                            w_clr_en    = 1'b1;
                            w_clr_floor = w_floor_step;
                        end else if (!w_beyond) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_step_nxt = r_step + SW'(1);
                    end
                end
            end
            DOOR: begin
                w_clr_en = 1'b1;
                if (call_req[r_floor]) begin
                    w_dwell_nxt = '0;
                end else if (r_dwell == c_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // State, position and registered motor/door outputs.
    always_ff @(posedge CLOCK_50 or negedge Clear_b) begin
        if (!Clear_b) begin
            r_state <= IDLE;
            r_dir   <= DIR_UP;
            r_floor <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_stop  <= 1'b1;
            r_door  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_floor <= w_floor_nxt;
            r_step  <= w_step_nxt;
            r_dwell <= w_dwell_nxt;
            r_stop  <= (w_state_nxt != MOVE);
            r_door  <= (w_state_nxt == DOOR);
        end
    end

    assign motor_dir  = r_dir;
    assign motor_stop = r_stop;
    assign floor      = r_floor;
    assign door_open  = r_door;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_scheduler
//  Description : Self-checking bench for elevator_scheduler with directed
//                scenarios and a randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    localparam int NF    = 4;
    localparam int STEPS = 4;
    localparam int DWELL = 8;

    logic          CLOCK_50;
    logic          Clear_b;
    logic [NF-1:0] call_req;
    logic          step_tick;
    logic          motor_dir;
    logic          motor_stop;
    logic [1:0]    floor;
    logic [NF-1:0] pending;
    logic          door_open;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;

    elevator_scheduler #(
        .NUM_FLOORS      (NF),
        .STEPS_PER_FLOOR (STEPS),
        .DOOR_CYCLES     (DWELL)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Clear_b    (Clear_b),
        .call_req   (call_req),
        .step_tick  (step_tick),
        .motor_dir  (motor_dir),
        .motor_stop (motor_stop),
        .floor      (floor),
        .pending    (pending),
        .door_open  (door_open),
        .state      (state)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Behavioural model: mode 0 parked, 1 travelling, 2 doors open.
    int       m_floor;
    int       m_mode;
    int       m_ticks_left;
    int       m_door_left;
    bit       m_dir;
    bit [3:0] m_pend;

    function automatic bit wants(bit [3:0] v, int f, bit up);
        for (int i = 0; i < NF; i++) begin
            if ((up && i > f) || (!up && i < f)) begin
                if (v[i]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_floor = 0; m_mode = 0; m_ticks_left = STEPS; m_door_left = DWELL;
        m_dir = 1'b1; m_pend = 4'b0000;
    endfunction

    function automatic void model_edge(bit [3:0] c, bit t);
        bit [3:0] clr;
        bit [3:0] seen;
        clr  = 4'b0000;
        seen = m_pend | c;
        if (m_mode == 0) begin
            if (m_pend[m_floor]) begin
                m_mode = 2; m_door_left = DWELL; clr[m_floor] = 1'b1;
            end else if (wants(m_pend, m_floor, m_dir)) begin
                m_mode = 1; m_ticks_left = STEPS;
            end else if (wants(m_pend, m_floor, !m_dir)) begin
                m_dir = !m_dir; m_mode = 1; m_ticks_left = STEPS;
            end
        end else if (m_mode == 1) begin
            if (t) begin
                m_ticks_left--;
                if (m_ticks_left == 0) begin
                    m_floor      = m_dir ? m_floor + 1 : m_floor - 1;
                    m_ticks_left = STEPS;
                    if (seen[m_floor]) begin
                        m_mode = 2; m_door_left = DWELL; clr[m_floor] = 1'b1;
                    end else if (!wants(seen, m_floor, m_dir)) begin
                        m_mode = 0;
                    end
                end
            end
        end else begin
            clr[m_floor] = 1'b1;
            if (c[m_floor]) m_door_left = DWELL;
            else            m_door_left--;
            if (m_door_left == 0) m_mode = 0;
        end
        m_pend = seen & ~clr;
    endfunction

    // One clock with the given inputs; outputs settle 1 time unit after the edge.
    task automatic cyc(input logic [3:0] c, input logic t);
        call_req  = c;
        step_tick = t;
        @(posedge CLOCK_50);
        model_edge(c, t);
        #1;
    endtask

    task automatic apply_reset();
        call_req  = 4'b0000;
        step_tick = 1'b0;
        Clear_b   = 1'b0;
        model_reset();
        #2;
        @(posedge CLOCK_50);
        #1;
        Clear_b = 1'b1;
    endtask

    // Counts door_open cycles starting from a cycle where it is already high.
    task automatic dwell_len(input logic t, output int n);
        n = 1;
        for (int k = 0; k < 40 && door_open; k++) begin
            cyc(4'b0000, t);
            if (door_open) n++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (floor !== 2'd0)        begin errors++; $display("FAIL reset_floor got=%0d exp=0", floor); end
        checks++; if (pending !== 4'b0000)   begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (motor_stop !== 1'b1)   begin errors++; $display("FAIL reset_stop got=%b exp=1", motor_stop); end
        checks++; if (door_open !== 1'b0)    begin errors++; $display("FAIL reset_door got=%b exp=0", door_open); end
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (motor_dir !== 1'b1)    begin errors++; $display("FAIL reset_dir got=%b exp=1", motor_dir); end
    endtask

    task automatic test_single_trip();
        int n;
        apply_reset();
        cyc(4'b0100, 1'b0);
        checks++; if (pending !== 4'b0100)   begin errors++; $display("FAIL trip_latch got=%b exp=0100", pending); end
        checks++; if (motor_stop !== 1'b1)   begin errors++; $display("FAIL trip_still got=%b exp=1", motor_stop); end
        cyc(4'b0000, 1'b0);
        checks++; if (motor_stop !== 1'b0)   begin errors++; $display("FAIL trip_go got=%b exp=0", motor_stop); end
        checks++; if (motor_dir !== 1'b1)    begin errors++; $display("FAIL trip_dir got=%b exp=1", motor_dir); end
        repeat (7) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd1 || state !== 2'd1) begin errors++; $display("FAIL trip_mid got floor=%0d state=%0d exp floor=1 state=1", floor, state); end
        cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd2)        begin errors++; $display("FAIL trip_floor got=%0d exp=2", floor); end
        checks++; if (motor_stop !== 1'b1 || door_open !== 1'b1) begin errors++; $display("FAIL trip_arrive got stop=%b door=%b exp 1 1", motor_stop, door_open); end
        checks++; if (pending !== 4'b0000)   begin errors++; $display("FAIL trip_clear got=%b exp=0000", pending); end
        dwell_len(1'b0, n);
        checks++; if (n !== DWELL)           begin errors++; $display("FAIL trip_dwell got=%0d exp=%0d", n, DWELL); end
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL trip_idle got=%0d exp=0", state); end
    endtask

    task automatic goto_floor1();
        int n;
        apply_reset();
        cyc(4'b0010, 1'b0);
        cyc(4'b0000, 1'b0);
        repeat (4) cyc(4'b0000, 1'b1);
        dwell_len(1'b0, n);
    endtask

    task automatic test_scan_order();
        int n;
        goto_floor1();
        cyc(4'b1000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b1);
        cyc(4'b0101, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd2 || door_open !== 1'b1) begin errors++; $display("FAIL scan_stop2 got floor=%0d door=%b exp 2 1", floor, door_open); end
        checks++; if (pending !== 4'b1001)   begin errors++; $display("FAIL scan_pend2 got=%b exp=1001", pending); end
        dwell_len(1'b0, n);
        checks++; if (n !== DWELL)           begin errors++; $display("FAIL scan_dwell2 got=%0d exp=%0d", n, DWELL); end
        cyc(4'b0000, 1'b0);
        checks++; if (state !== 2'd1 || motor_dir !== 1'b1) begin errors++; $display("FAIL scan_up got state=%0d dir=%b exp 1 1", state, motor_dir); end
        repeat (4) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd3 || door_open !== 1'b1 || pending !== 4'b0001) begin errors++; $display("FAIL scan_stop3 got floor=%0d door=%b pend=%b exp 3 1 0001", floor, door_open, pending); end
        dwell_len(1'b0, n);
        checks++; if (n !== DWELL)           begin errors++; $display("FAIL scan_dwell3 got=%0d exp=%0d", n, DWELL); end
        cyc(4'b0000, 1'b0);
        checks++; if (state !== 2'd1 || motor_dir !== 1'b0) begin errors++; $display("FAIL scan_down got state=%0d dir=%b exp 1 0", state, motor_dir); end
        repeat (8) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd1 || state !== 2'd1) begin errors++; $display("FAIL scan_pass got floor=%0d state=%0d exp 1 1", floor, state); end
        repeat (4) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd0 || door_open !== 1'b1 || pending !== 4'b0000) begin errors++; $display("FAIL scan_stop0 got floor=%0d door=%b pend=%b exp 0 1 0000", floor, door_open, pending); end
        dwell_len(1'b0, n);
        checks++; if (n !== DWELL)           begin errors++; $display("FAIL scan_dwell0 got=%0d exp=%0d", n, DWELL); end
    endtask

    task automatic test_current_floor_call();
        int n;
        bit moved;
        goto_floor1();
        moved = 1'b0;
        cyc(4'b0010, 1'b0);
        checks++; if (door_open !== 1'b0 || pending !== 4'b0010) begin errors++; $display("FAIL cur_latch got door=%b pend=%b exp 0 0010", door_open, pending); end
        cyc(4'b0000, 1'b0);
        checks++; if (door_open !== 1'b1 || pending !== 4'b0000) begin errors++; $display("FAIL cur_open got door=%b pend=%b exp 1 0000", door_open, pending); end
        n = 1;
        repeat (4) begin
            cyc(4'b0000, 1'b0);
            if (door_open) n++;
            if (!motor_stop) moved = 1'b1;
        end
        cyc(4'b0010, 1'b0);
        if (door_open) n++;
        checks++; if (pending !== 4'b0000)   begin errors++; $display("FAIL cur_nolatch got=%b exp=0000", pending); end
        for (int k = 0; k < 40 && door_open; k++) begin
            cyc(4'b0000, 1'b0);
            if (door_open) n++;
            if (!motor_stop) moved = 1'b1;
        end
        checks++; if (n !== 5 + DWELL)       begin errors++; $display("FAIL cur_extend got=%0d exp=%0d", n, 5 + DWELL); end
        checks++; if (moved || floor !== 2'd1) begin errors++; $display("FAIL cur_nomove got moved=%b floor=%0d exp 0 1", moved, floor); end
    endtask

    task automatic test_reset_mid_move();
        int n;
        goto_floor1();
        cyc(4'b0100, 1'b0);
        cyc(4'b0000, 1'b0);
        repeat (4) cyc(4'b0000, 1'b1);
        dwell_len(1'b0, n);
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        checks++; if (motor_dir !== 1'b0 || motor_stop !== 1'b0) begin errors++; $display("FAIL mid_down got dir=%b stop=%b exp 0 0", motor_dir, motor_stop); end
        repeat (2) cyc(4'b0000, 1'b1);
        Clear_b = 1'b0;
        model_reset();
        #1;
        checks++; if (floor !== 2'd0 || motor_stop !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL mid_reset got floor=%0d stop=%b state=%0d exp 0 1 0", floor, motor_stop, state); end
        checks++; if (pending !== 4'b0000 || door_open !== 1'b0 || motor_dir !== 1'b1) begin errors++; $display("FAIL mid_reset2 got pend=%b door=%b dir=%b exp 0000 0 1", pending, door_open, motor_dir); end
        @(posedge CLOCK_50);
        #1;
        Clear_b = 1'b1;
        repeat (10) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd0 || motor_stop !== 1'b1) begin errors++; $display("FAIL mid_still got floor=%0d stop=%b exp 0 1", floor, motor_stop); end
    endtask

    task automatic test_ignored_ticks();
        int n;
        apply_reset();
        repeat (6) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd0 || state !== 2'd0) begin errors++; $display("FAIL ign_idle got floor=%0d state=%0d exp 0 0", floor, state); end
        cyc(4'b0010, 1'b0);
        cyc(4'b0000, 1'b0);
        repeat (3) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd0 || state !== 2'd1) begin errors++; $display("FAIL ign_three got floor=%0d state=%0d exp 0 1", floor, state); end
        cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd1 || door_open !== 1'b1) begin errors++; $display("FAIL ign_four got floor=%0d door=%b exp 1 1", floor, door_open); end
        dwell_len(1'b1, n);
        checks++; if (n !== DWELL || floor !== 2'd1) begin errors++; $display("FAIL ign_door got dwell=%0d floor=%0d exp %0d 1", n, floor, DWELL); end
        cyc(4'b0100, 1'b0);
        cyc(4'b0000, 1'b0);
        repeat (3) cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd1)        begin errors++; $display("FAIL ign_next3 got=%0d exp=1", floor); end
        cyc(4'b0000, 1'b1);
        checks++; if (floor !== 2'd2 || door_open !== 1'b1) begin errors++; $display("FAIL ign_next4 got floor=%0d door=%b exp 2 1", floor, door_open); end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic       t;
        apply_reset();
        for (int cycle = 0; cycle < 3000; cycle++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                for (int b = 0; b < NF; b++) c[b] = ($urandom_range(0, 11) == 0);
                t = ($urandom_range(0, 1) == 1);
                cyc(c, t);
            end
            checks++; if (floor !== 2'(m_floor))        begin errors++; $display("FAIL rnd_floor cyc=%0d got=%0d exp=%0d", cycle, floor, m_floor); end
            checks++; if (pending !== m_pend)           begin errors++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", cycle, pending, m_pend); end
            checks++; if (state !== 2'(m_mode))         begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cycle, state, m_mode); end
            checks++; if (motor_dir !== m_dir)          begin errors++; $display("FAIL rnd_dir cyc=%0d got=%b exp=%b", cycle, motor_dir, m_dir); end
            checks++; if (motor_stop !== (m_mode != 1)) begin errors++; $display("FAIL rnd_stop cyc=%0d got=%b exp=%b", cycle, motor_stop, (m_mode != 1)); end
            checks++; if (door_open !== (m_mode == 2))  begin errors++; $display("FAIL rnd_door cyc=%0d got=%b exp=%b", cycle, door_open, (m_mode == 2)); end
        end
    endtask

    initial begin
        Clear_b   = 1'b0;
        call_req  = 4'b0000;
        step_tick = 1'b0;
        model_reset();
        test_reset();
        test_single_trip();
        test_scan_order();
        test_current_floor_call();
        test_reset_mid_move();
        test_ignored_ticks();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
